fp_operand_dispatcher: RTL and testbench

FP_OPERAND_DISPATCHER -- requirements
Module: fp_operand_dispatcher

---
 rtl/fp_operand_dispatcher.sv | 130 +++++++++++++
 tb/tb_fp_operand_dispatcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_dispatcher.sv
// rtl/fp_operand_dispatcher.sv - operand FIFO feeding an exception checker through an IDLE/ISSUE/GAP handshake
// Captures the qualified exception code per operand, or 3'b111 when the checker never acknowledges.
module fp_operand_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Data,
  output logic        Data_valid,
  input  logic [2:0]  Exc,
  input  logic        ACK,
  output logic [31:0] res_data,
  output logic [2:0]  res_exc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  timeout_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [WW-1:0] wait_cnt;
  logic          push;
  logic          pop;
  logic          ack_hit;
  logic          to_hit;
  logic          capture;

  assign in_ready   = (count < FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && (count != '0) && (!res_valid || res_ready);
  assign ack_hit    = (state == S_ISSUE) && ACK;
  assign to_hit     = (state == S_ISSUE) && !ACK && (wait_cnt == WAIT_LAST);
  assign capture    = ack_hit || to_hit;
  // Decoded straight from state so an asynchronous reset drops it without waiting for an edge.
  assign Data_valid = (state == S_ISSUE);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      Data        <= '0;
      wait_cnt    <= '0;
      res_data    <= '0;
      res_exc     <= '0;
      res_valid   <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_ISSUE;
            Data     <= mem[rd_ptr];
            wait_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (capture) begin
            state <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Exc is only meaningful for an all-ones exponent; anything else is a stale code.
      if (capture) begin
        res_data  <= Data;
        res_valid <= 1'b1;
        if (to_hit) begin
          res_exc <= 3'b111;
        end else if (Data[30:23] == 8'hFF) begin
          res_exc <= Exc;
        end else begin
          res_exc <= 3'b000;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      if (to_hit && (timeout_cnt != 8'hFF)) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_operand_dispatcher.sv
// tb/tb_fp_operand_dispatcher.sv - directed-vector bench for fp_operand_dispatcher
module tb_fp_operand_dispatcher;

  logic        CLK;
  logic        RSTN;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Data;
  logic        Data_valid;
  logic [2:0]  Exc;
  logic        ACK;
  logic [31:0] res_data;
  logic [2:0]  res_exc;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  timeout_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] xv [6];
  logic        dv_exp [5];

  fp_operand_dispatcher #(.DEPTH(4), .TIMEOUT(16)) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Data        (Data),
    .Data_valid  (Data_valid),
    .Exc         (Exc),
    .ACK         (ACK),
    .res_data    (res_data),
    .res_exc     (res_exc),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .timeout_cnt (timeout_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_dv(input int max);
    int n;
    n = 0;
    while (!Data_valid && n < max) begin
      step();
      n++;
    end
    check("dv_seen", 32'(Data_valid), 32'd1);
  endtask

  task automatic ack_now(input logic [2:0] e);
    ACK = 1'b1;
    Exc = e;
    step();
    ACK = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    xv[0] = 32'h4000_0001; xv[1] = 32'h4000_0002; xv[2] = 32'h4000_0003;
    xv[3] = 32'h4000_0004; xv[4] = 32'h4000_0005; xv[5] = 32'h4000_0006;
    dv_exp[0] = 1'b0; dv_exp[1] = 1'b1; dv_exp[2] = 1'b0; dv_exp[3] = 1'b0; dv_exp[4] = 1'b1;

    RSTN = 1'b0; in_data = '0; in_valid = 1'b0; Exc = '0; ACK = 1'b0; res_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_dv", 32'(Data_valid), 32'd0);
    check("rst_data", Data, 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_exc", 32'(res_exc), 32'd0);
    check("rst_to_cnt", 32'(timeout_cnt), 32'd0);
    RSTN = 1'b1;
    step();

    // infinity with a live Inf code
    push(32'h7F80_0000);
    wait_dv(8);
    check("inf_data", Data, 32'h7F80_0000);
    ack_now(3'b011);
    check("inf_res_valid", 32'(res_valid), 32'd1);
    check("inf_res_data", res_data, 32'h7F80_0000);
    check("inf_res_exc", 32'(res_exc), 32'd3);
    check("inf_gap_dv", 32'(Data_valid), 32'd0);
    consume();
    check("inf_consumed", 32'(res_valid), 32'd0);

    // finite operand with stale NaN code
    Exc = 3'b100;
    push(32'h3F80_0000);
    wait_dv(8);
    ack_now(3'b100);
    check("fin_res_data", res_data, 32'h3F80_0000);
    check("fin_res_exc", 32'(res_exc), 32'd0);
    consume();

    // timeout: 16 ISSUE cycles with no ACK
    Exc = 3'b000;
    push(32'h4000_0000);
    wait_dv(8);
    repeat (15) step();
    check("to_still_issue", 32'(Data_valid), 32'd1);
    check("to_no_res_yet", 32'(res_valid), 32'd0);
    step();
    check("to_res_valid", 32'(res_valid), 32'd1);
    check("to_res_exc", 32'(res_exc), 32'd7);
    check("to_res_data", res_data, 32'h4000_0000);
    check("to_cnt", 32'(timeout_cnt), 32'd1);
    check("to_gap_dv", 32'(Data_valid), 32'd0);
    ack_now(3'b011);
    check("gap_ack_ignored_exc", 32'(res_exc), 32'd7);
    check("gap_ack_ignored_dv", 32'(Data_valid), 32'd0);
    consume();

    // back-to-back with same-cycle ACK
    res_ready = 1'b1;
    in_data = 32'h4040_0000; in_valid = 1'b1;
    step();
    in_data = 32'h40A0_0000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b_dv%0d", i), 32'(Data_valid), 32'(dv_exp[i]));
      ACK = Data_valid;
      step();
      if (i == 0) in_valid = 1'b0;
      if (i == 1) begin
        check("b2b_res_a", res_data, 32'h4040_0000);
        check("b2b_valid_a", 32'(res_valid), 32'd1);
      end
    end
    ACK = 1'b0;
    check("b2b_res_b", res_data, 32'h40A0_0000);
    check("b2b_exc_b", 32'(res_exc), 32'd0);
    repeat (2) step();
    res_ready = 1'b0;

    // full FIFO with a stalled consumer
    for (int i = 0; i < 5; i++) begin
      in_data = xv[i]; in_valid = 1'b1;
      step();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_issued", Data, xv[0]);
    in_data = xv[5];
    repeat (3) step();
    check("full_held", 32'(in_ready), 32'd0);
    ack_now(3'b000);
    check("full_res0", res_data, xv[0]);
    step();
    step();
    check("stall_no_pop_rdy", 32'(in_ready), 32'd0);
    check("stall_no_pop_dv", 32'(Data_valid), 32'd0);
    res_ready = 1'b1;
    step();
    check("pop_in_ready", 32'(in_ready), 32'd1);
    check("pop_data1", Data, xv[1]);
    step();
    in_valid = 1'b0;
    check("refill_in_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k < 6; k++) begin
      wait_dv(8);
      check($sformatf("drain_data%0d", k), Data, xv[k]);
      ack_now(3'b000);
      check($sformatf("drain_res%0d", k), res_data, xv[k]);
    end
    repeat (2) step();
    res_ready = 1'b0;

    // reset during ISSUE
    push(32'h4100_0000);
    push(32'h4110_0000);
    wait_dv(8);
    check("prerst_dv", 32'(Data_valid), 32'd1);
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_async_dv", 32'(Data_valid), 32'd0);
    check("rst_async_data", Data, 32'd0);
    check("rst_async_rdy", 32'(in_ready), 32'd1);
    check("rst_async_res_valid", 32'(res_valid), 32'd0);
    check("rst_async_res_data", res_data, 32'd0);
    check("rst_async_res_exc", 32'(res_exc), 32'd0);
    check("rst_async_to_cnt", 32'(timeout_cnt), 32'd0);
    step();
    RSTN = 1'b1;
    repeat (4) step();
    check("rst_fifo_empty_dv", 32'(Data_valid), 32'd0);
    check("rst_fifo_empty_rdy", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
